// File: rtl/serial_collector_if.sv
// Bundle of the serial input and word output handshakes of serial_collector.
// The slave modport is the collector itself; master is the bit source / word consumer.
interface serial_collector_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             clr;
    logic             dir;
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ack;
    logic [CW-1:0]    bit_cnt;
    logic             ovf;

    modport master (
        output clr, dir, sin, sin_valid, dout_ack,
        input  sin_ready, dout, dout_valid, bit_cnt, ovf
    );

    modport slave (
        input  clr, dir, sin, sin_valid, dout_ack,
        output sin_ready, dout, dout_valid, bit_cnt, ovf
    );
endinterface

// File: rtl/serial_collector.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words LSB- or MSB-first into a
// double-buffered valid/ack output register, stalling only the final bit of a word.
module serial_collector #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_collector_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic             word_dir;
    logic             last_bit;
    logic             ready;
    logic             acc;
    logic             complete;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             ovf_q;

    always_comb begin
        // NOTE: every variable gets a value on every path through this block;
        // a missing default here would infer a latch.
        last_bit  = (cnt == LAST);
        ready     = !(last_bit && dout_valid_q && !bus.dout_ack);
        acc       = bus.sin_valid && ready;
        complete  = acc && last_bit;
        // The direction sampled with bit 0 governs the rest of the word.
        word_dir  = (cnt == '0) ? bus.dir : dir_q;
        shreg_nxt = shreg;
        if (word_dir) begin
            shreg_nxt = {bus.sin, shreg[WIDTH-1:1]};
        end else begin
            shreg_nxt = {shreg[WIDTH-2:0], bus.sin};
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            cnt          <= '0;
            dir_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (bus.clr) begin
            shreg        <= '0;
            cnt          <= '0;
            dir_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (acc) begin
                if (cnt == '0) begin
                    dir_q <= bus.dir;
                end
                if (last_bit) begin
                    shreg  <= '0;
                    cnt    <= '0;
                    dout_q <= shreg_nxt;
                end else begin
                    shreg <= shreg_nxt;
                    cnt   <= cnt + CW'(1);
                end
            end

            // A completing word overrides the ack so back-to-back words see no bubble.
            if (complete) begin
                dout_valid_q <= 1'b1;
            end else if (bus.dout_ack && dout_valid_q) begin
                dout_valid_q <= 1'b0;
            end

            if (bus.sin_valid && !ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.sin_ready  = ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.bit_cnt    = cnt;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_serial_collector.sv
// Self-checking bench for serial_collector: directed scenarios plus random traffic,
// all scored against a word-level model built from a queue of received bits.
module tb_serial_collector;
    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    serial_collector_if #(.WIDTH(W)) bus ();

    serial_collector #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits of the current word, the direction of that word,
    // and the output register contents.
    int         m_bits[$];
    logic       m_dir;
    logic [W-1:0] m_dout;
    logic       m_vld;
    logic       m_ovf;

    function automatic void m_reset();
        m_bits.delete();
        m_dir  = 1'b0;
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    function automatic logic [W-1:0] m_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (m_dir) w[i] = m_bits[i][0];
            else       w[W-1-i] = m_bits[i][0];
        end
        return w;
    endfunction

    // One clock: drive inputs at negedge, score sin_ready before the edge and
    // registered outputs after it.
    task automatic drive_cycle(input logic c, input logic d, input logic s,
                               input logic v, input logic a);
        logic exp_ready;
        logic [CW-1:0] exp_cnt;
        @(negedge clk);
        bus.clr = c; bus.dir = d; bus.sin = s; bus.sin_valid = v; bus.dout_ack = a;
        #1;
        exp_ready = !((m_bits.size() == W - 1) && m_vld && !a);
        vectors++;
        if (bus.sin_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL sin_ready: got %b want %b at %0t", bus.sin_ready, exp_ready, $time);
        end
        if (c) begin
            m_reset();
        end else begin
            if (v && !exp_ready) m_ovf = 1'b1;
            if (v && exp_ready) begin
                if (m_bits.size() == 0) m_dir = d;
                m_bits.push_back(int'(s));
            end
            if (m_bits.size() == W) begin
                m_dout = m_word();
                m_vld  = 1'b1;
                m_bits.delete();
            end else if (a && m_vld) begin
                m_vld = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        exp_cnt = CW'(m_bits.size());
        vectors++;
        if (bus.dout !== m_dout) begin
            miscompares++;
            $display("FAIL dout: got %h want %h at %0t", bus.dout, m_dout, $time);
        end
        vectors++;
        if (bus.dout_valid !== m_vld) begin
            miscompares++;
            $display("FAIL dout_valid: got %b want %b at %0t", bus.dout_valid, m_vld, $time);
        end
        vectors++;
        if (bus.bit_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL bit_cnt: got %0d want %0d at %0t", bus.bit_cnt, exp_cnt, $time);
        end
        vectors++;
        if (bus.ovf !== m_ovf) begin
            miscompares++;
            $display("FAIL ovf: got %b want %b at %0t", bus.ovf, m_ovf, $time);
        end
        bus.clr = 1'b0; bus.dout_ack = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] val, input logic d,
                             input logic ack_last, input logic toggle_dir);
        logic b;
        logic dd;
        for (int i = 0; i < W; i++) begin
            b  = d ? val[i] : val[W-1-i];
            dd = (toggle_dir && i >= 3) ? ~d : d;
            drive_cycle(1'b0, dd, b, 1'b1, (i == W - 1) ? ack_last : 1'b0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.sin_valid = 1'b0; bus.dout_ack = 1'b0; bus.clr = 1'b0;
        rst = 1'b1;
        #1;
        m_reset();
        vectors++;
        if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.bit_cnt !== '0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got dout=%h vld=%b cnt=%0d ovf=%b want all 0",
                     bus.dout, bus.dout_valid, bus.bit_cnt, bus.ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clr = 1'b0; bus.dir = 1'b0; bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.dout_ack = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.bit_cnt !== '0 ||
            bus.ovf !== 1'b0 || bus.sin_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got dout=%h vld=%b cnt=%0d ovf=%b rdy=%b want 0/0/0/0/1",
                     bus.dout, bus.dout_valid, bus.bit_cnt, bus.ovf, bus.sin_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lsb_first();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.dout !== 8'hA5 || bus.dout_valid !== 1'b1 || bus.bit_cnt !== '0) begin
            miscompares++;
            $display("FAIL lsb_first: got dout=%h vld=%b cnt=%0d want a5/1/0",
                     bus.dout, bus.dout_valid, bus.bit_cnt);
        end
    endtask

    task automatic test_msb_first();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.dout !== 8'h3C || bus.dout_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL msb_first: got dout=%h vld=%b want 3c/1", bus.dout, bus.dout_valid);
        end
        send_word(8'h3C, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (bus.dout !== 8'h3C || bus.dout_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL dir_toggle: got dout=%h vld=%b want 3c/1", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v2;
        v2 = 8'h22;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < W - 1; i++) drive_cycle(1'b0, 1'b1, v2[i], 1'b1, 1'b0);
        vectors++;
        if (bus.bit_cnt !== CW'(W - 1) || bus.sin_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall: got cnt=%0d rdy=%b want 7/0", bus.bit_cnt, bus.sin_ready);
        end
        drive_cycle(1'b0, 1'b1, v2[W-1], 1'b1, 1'b0);
        vectors++;
        if (bus.ovf !== 1'b1 || bus.dout !== 8'h11 || bus.bit_cnt !== CW'(W - 1)) begin
            miscompares++;
            $display("FAIL bp_drop: got ovf=%b dout=%h cnt=%0d want 1/11/7",
                     bus.ovf, bus.dout, bus.bit_cnt);
        end
        drive_cycle(1'b0, 1'b1, v2[W-1], 1'b1, 1'b1);
        vectors++;
        if (bus.dout !== 8'h22 || bus.dout_valid !== 1'b1 || bus.bit_cnt !== '0) begin
            miscompares++;
            $display("FAIL bp_release: got dout=%h vld=%b cnt=%0d want 22/1/0",
                     bus.dout, bus.dout_valid, bus.bit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.dout !== 8'h5A || bus.dout_valid !== 1'b1 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back: got dout=%h vld=%b ovf=%b want 5a/1/0",
                     bus.dout, bus.dout_valid, bus.ovf);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] v;
        v = 8'h96;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, v[i], 1'b1, 1'b0);
        apply_reset();
        send_word(8'h96, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.dout !== 8'h96 || bus.dout_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: got dout=%h vld=%b want 96/1", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_clr_mid_word();
        logic [W-1:0] v;
        v = 8'h96;
        send_word(8'h33, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < W - 1; i++) drive_cycle(1'b0, 1'b1, v[i], 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, v[W-1], 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, v[W-1], 1'b1, 1'b1);
        vectors++;
        if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.bit_cnt !== '0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_mid: got dout=%h vld=%b cnt=%0d ovf=%b want all 0",
                     bus.dout, bus.dout_valid, bus.bit_cnt, bus.ovf);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, v[i], 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h96, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.dout !== 8'h96 || bus.dout_valid !== 1'b1 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_word: got dout=%h vld=%b ovf=%b want 96/1/0",
                     bus.dout, bus.dout_valid, bus.ovf);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] v;
        logic [CW-1:0] held;
        v = 8'hC3;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            int gaps;
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                held = bus.bit_cnt;
                drive_cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
                vectors++;
                if (bus.bit_cnt !== held) begin
                    miscompares++;
                    $display("FAIL gap_hold: got cnt=%0d want %0d", bus.bit_cnt, held);
                end
            end
            drive_cycle(1'b0, 1'b0, v[W-1-i], 1'b1, 1'b0);
        end
        vectors++;
        if (bus.dout !== 8'hC3 || bus.dout_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps: got dout=%h vld=%b want c3/1", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) apply_reset();
            drive_cycle(($urandom_range(0, 63) == 0),
                        1'($urandom),
                        1'($urandom),
                        ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 2) == 0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_clr_mid_word();
        test_gaps();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
